// File: rtl/queue2_cmd_unpack_pkg.sv
// rtl/queue2_cmd_unpack_pkg.sv - opcodes, command encoding and state for the queue2 command unpacker
package queue2_cmd_unpack_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_ERASE = 8'h03;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_ERASE = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG,
    ST_DRAIN,
    ST_ISSUE
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_NOP) || (op == OP_READ) || (op == OP_WRITE) || (op == OP_ERASE);
  endfunction

endpackage

// File: rtl/queue2_cmd_unpack.sv
// rtl/queue2_cmd_unpack.sv - decodes queue2 words into READ/WRITE/ERASE commands for the sequencer
module queue2_cmd_unpack
  import queue2_cmd_unpack_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_q_vld,
  input  logic [WIDTH-1:0]   i_q_data0,
  input  logic [WIDTH-1:0]   i_q_data1,
  output logic               o_q_rd,
  output logic               o_cmd_vld,
  input  logic               i_cmd_rdy,
  output logic [1:0]         o_cmd_op,
  output logic [WIDTH-9:0]   o_cmd_addr,
  output logic [WIDTH-1:0]   o_cmd_wdata,
  output logic               o_err,
  output logic               o_busy
);

  state_e             state_q;
  cmd_op_e            op_q;
  logic [WIDTH-9:0]   addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               vld_q;
  logic               err_q;
  logic               busy_q;
  logic [7:0]         head_op;

  assign head_op = i_q_data0[WIDTH-1 -: 8];

  // DRAIN pops the data word that was already latched from the next-entry slot
  always_comb begin
    o_q_rd = 1'b0;
    case (state_q)
      ST_IDLE:  o_q_rd = i_q_vld[0];
      ST_ARG:   o_q_rd = i_q_vld[0];
      ST_DRAIN: o_q_rd = 1'b1;
      default:  o_q_rd = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= CMD_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_q_vld[0]) begin
            if (!op_known(head_op)) begin
              err_q <= 1'b1;
            end else if (head_op == OP_READ || head_op == OP_ERASE) begin
              op_q    <= cmd_op_e'(head_op[1:0]);
              addr_q  <= i_q_data0[WIDTH-9:0];
              vld_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_ISSUE;
            end else if (head_op == OP_WRITE) begin
              op_q   <= CMD_WRITE;
              addr_q <= i_q_data0[WIDTH-9:0];
              busy_q <= 1'b1;
              if (i_q_vld[1]) begin
                wdata_q <= i_q_data1;
                vld_q   <= 1'b1;
                state_q <= ST_DRAIN;
              end else begin
                state_q <= ST_ARG;
              end
            end
          end
        end
        ST_ARG: begin
          if (i_q_vld[0]) begin
            wdata_q <= i_q_data0;
            vld_q   <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (i_cmd_rdy) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_cmd_rdy) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_vld   = vld_q;
  assign o_cmd_op    = op_q;
  assign o_cmd_addr  = addr_q;
  assign o_cmd_wdata = wdata_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;

endmodule
